muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_pkg.sv | 27 ++
 rtl/muldiv_negate.sv | 16 +
 rtl/muldiv_unit.sv | 184 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Op encodings, FSM state type and small op-decoding helpers.
// Imported by muldiv_unit; muldiv_negate is type-free.
package muldiv_pkg;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } state_t;

    // Bit 1 of the op selects divide, bit 0 selects two's-complement operands.
    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return op[0];
    endfunction

endpackage

// File: rtl/muldiv_negate.sv
// Conditional two's-complement negator: res = neg ? -val : val.
// Latency: combinational, zero cycles.
// Backpressure: none, pure function of its inputs.
module muldiv_negate #(
    parameter int WIDTH = 32
) (
    input  logic             neg_i,
    input  logic [WIDTH-1:0] val_i,
    output logic [WIDTH-1:0] res_o
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    assign res_o = neg_i ? ((~val_i) + ONE) : val_i;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULTU/MULT/DIVU/DIV unit: shift-add multiply, restoring divide on magnitudes.
// Latency: done high WIDTH+2 edges after the accepting edge; divide-by-zero after one edge.
// Backpressure: start is only sampled in IDLE (busy=0); cancel aborts RUN/FIX without a done.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int               CNT_W    = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic               neg_res_q, neg_res_d;   // quotient/product sign flips
    logic               neg_rem_q, neg_rem_d;   // remainder follows dividend sign
    logic               dz_q, dz_d;             // pending divide-by-zero flag
    logic [WIDTH-1:0]   acc_q, acc_d;           // product upper half / partial remainder
    logic [WIDTH-1:0]   sh_q, sh_d;             // multiplier -> product lower half / dividend -> quotient
    logic [WIDTH-1:0]   opnd_q, opnd_d;         // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;
    logic               dbz_q, dbz_d;

    logic [WIDTH-1:0]   a_mag, b_mag, acc_neg, sh_neg;
    logic               a_neg, b_neg;
    logic [WIDTH:0]     mul_addend, mul_sum;
    logic [WIDTH:0]     div_shift, div_diff;
    logic               div_ge;

    assign a_neg = op_is_signed(op) & a[WIDTH-1];
    assign b_neg = op_is_signed(op) & b[WIDTH-1];

    muldiv_negate #(.WIDTH(WIDTH)) u_neg_a   (.neg_i(a_neg), .val_i(a),     .res_o(a_mag));
    muldiv_negate #(.WIDTH(WIDTH)) u_neg_b   (.neg_i(b_neg), .val_i(b),     .res_o(b_mag));
    muldiv_negate #(.WIDTH(WIDTH)) u_neg_acc (.neg_i(1'b1),  .val_i(acc_q), .res_o(acc_neg));
    muldiv_negate #(.WIDTH(WIDTH)) u_neg_sh  (.neg_i(1'b1),  .val_i(sh_q),  .res_o(sh_neg));

    // One iteration of each algorithm; the divide borrow is bit WIDTH of the
    // difference because the shifted remainder is always below twice the divisor.
    assign mul_addend = sh_q[0] ? {1'b0, opnd_q} : '0;
    assign mul_sum    = {1'b0, acc_q} + mul_addend;
    assign div_shift  = {acc_q, sh_q[WIDTH-1]};
    assign div_diff   = div_shift - {1'b0, opnd_q};
    assign div_ge     = ~div_diff[WIDTH];

    // Next-state, datapath and output-register control.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        acc_d     = acc_q;
        sh_d      = sh_q;
        opnd_d    = opnd_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        dbz_d     = dbz_q;

        case (state_q)
            IDLE: begin
                if (start && !cancel) begin
                    is_div_d  = op_is_div(op);
                    neg_res_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    cnt_d     = '0;
                    dbz_d     = 1'b0;
                    if (op_is_div(op) && (b == '0)) begin
                        acc_d   = a;
                        sh_d    = '1;
                        dz_d    = 1'b1;
                        state_d = DONE;
                    end else begin
                        acc_d   = '0;
                        sh_d    = op_is_div(op) ? a_mag : b_mag;
                        opnd_d  = op_is_div(op) ? b_mag : a_mag;
                        dz_d    = 1'b0;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (cancel) begin
                    state_d = IDLE;
                end else begin
                    if (is_div_q) begin
                        acc_d = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
                        sh_d  = {sh_q[WIDTH-2:0], div_ge};
                    end else begin
                        acc_d = mul_sum[WIDTH:1];
                        sh_d  = {mul_sum[0], sh_q[WIDTH-1:1]};
                    end
                    cnt_d = cnt_q + CNT_ONE;
                    if (cnt_q == CNT_LAST) begin
                        state_d = FIX;
                    end
                end
            end
            FIX: begin
                if (cancel) begin
                    state_d = IDLE;
                end else begin
                    if (is_div_q) begin
                        if (neg_res_q) sh_d  = sh_neg;
                        if (neg_rem_q) acc_d = acc_neg;
                    end else if (neg_res_q) begin
                        // 2*WIDTH negate: the carry into the upper half only
                        // survives when the lower half is zero.
                        sh_d  = sh_neg;
                        acc_d = (sh_q == '0) ? acc_neg : ~acc_q;
                    end
                    state_d = DONE;
                end
            end
            DONE: begin
                hi_d    = acc_q;
                lo_d    = sh_q;
                done_d  = 1'b1;
                dbz_d   = dz_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, all cleared by the asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            acc_q     <= '0;
            sh_q      <= '0;
            opnd_q    <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
            acc_q     <= acc_d;
            sh_q      <= sh_d;
            opnd_q    <= opnd_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            dbz_q     <= dbz_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit at WIDTH=32: vector table plus corner sequences.
// Inputs are driven and outputs sampled on the falling clock edge.
// Cancel, ignored start, back-to-back issue and asynchronous reset are exercised.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset, start, cancel;
    logic [1:0]   op;
    logic [W-1:0] a, b;
    logic         busy, done, div_by_zero;
    logic [W-1:0] hi, lo;

    int tests = 0;
    int fails = 0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .cancel(cancel), .busy(busy), .done(done), .hi(hi), .lo(lo),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          lat;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Entered just after a falling edge with the DUT idle; returns just after
    // the falling edge that follows the accepting rising edge.
    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("accept_busy", 64'(busy), 64'd1);
        check("done_one_cycle", 64'(done), 64'd0);
    endtask

    // lat = number of rising edges after the accepting edge until done is seen.
    task automatic wait_done(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end while (!done && lat < 100);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int lat;
        issue(v.op, v.a, v.b);
        wait_done(lat);
        check({tag, "_lat"}, 64'(lat), 64'(v.lat));
        check({tag, "_hi"},  64'(hi),  64'(v.hi));
        check({tag, "_lo"},  64'(lo),  64'(v.lo));
        check({tag, "_dbz"}, 64'(div_by_zero), 64'(v.dbz));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        int lat;

        vecs[0]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 34};
        vecs[1]  = '{OP_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 34};
        vecs[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34};
        vecs[3]  = '{OP_DIVU,  32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 1'b1, 1};
        vecs[4]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 34};
        vecs[5]  = '{OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 34};
        vecs[6]  = '{OP_MULT,  32'hFFFFFFFB, 32'hFFFFFFFA, 32'h00000000, 32'd30,       1'b0, 34};
        vecs[7]  = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 34};
        vecs[8]  = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 34};
        vecs[9]  = '{OP_MULTU, 32'h80000000, 32'd2,        32'h00000001, 32'h00000000, 1'b0, 34};
        vecs[10] = '{OP_DIV,   32'd5,        32'd0,        32'h00000005, 32'hFFFFFFFF, 1'b1, 1};
        vecs[11] = '{OP_MULTU, 32'd0,        32'd123,      32'h00000000, 32'h00000000, 1'b0, 34};
        vecs[12] = '{OP_DIV,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 1'b0, 34};
        vecs[13] = '{OP_MULT,  32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000001, 1'b0, 34};
        vecs[14] = '{OP_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 1'b0, 34};

        reset = 1'b1; start = 1'b0; cancel = 1'b0; op = 2'b00; a = '0; b = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hi",   64'(hi),   64'd0);
        check("rst_lo",   64'(lo),   64'd0);
        check("rst_dbz",  64'(div_by_zero), 64'd0);
        reset = 1'b0;

        // Each vector is issued in the done cycle of the previous one.
        for (int i = 0; i < 15; i++) begin
            run_vec(vecs[i], $sformatf("v%0d", i));
        end

        // Cancel in RUN cycle 10, with a divide-by-zero start raised mid-run.
        run_vec('{OP_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 34}, "pre_cancel");
        issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        for (int c = 2; c <= 10; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (c == 5) begin
                op = OP_DIVU; a = 32'd1; b = 32'd0; start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        check("run_busy",    64'(busy), 64'd1);
        check("run_hold_hi", 64'(hi),   64'd0);
        check("run_hold_lo", 64'(lo),   64'd12);
        cancel = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cancel = 1'b0;
        check("cancel_run_busy", 64'(busy), 64'd0);
        check("cancel_run_done", 64'(done), 64'd0);
        check("cancel_run_hi",   64'(hi),   64'd0);
        check("cancel_run_lo",   64'(lo),   64'd12);
        check("cancel_run_dbz",  64'(div_by_zero), 64'd0);
        pulses = 0;
        repeat (40) begin
            @(posedge clk);
            @(negedge clk);
            if (done) pulses++;
        end
        check("cancel_run_no_done", 64'(pulses), 64'd0);

        // Cancel in FIX.
        issue(OP_MULTU, 32'd2, 32'd3);
        repeat (W) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("fix_busy", 64'(busy), 64'd1);
        cancel = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cancel = 1'b0;
        check("cancel_fix_busy", 64'(busy), 64'd0);
        pulses = 0;
        repeat (5) begin
            if (done) pulses++;
            @(posedge clk);
            @(negedge clk);
        end
        check("cancel_fix_no_done", 64'(pulses), 64'd0);
        check("cancel_fix_lo", 64'(lo), 64'd12);

        // Cancel and start together in IDLE: start dropped.
        op = OP_MULTU; a = 32'd2; b = 32'd3; start = 1'b1; cancel = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        check("cancel_wins_busy", 64'(busy), 64'd0);

        // Cancel while in DONE has no effect.
        issue(OP_DIVU, 32'h55, 32'd0);
        cancel = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cancel = 1'b0;
        check("cancel_done_done", 64'(done), 64'd1);
        check("cancel_done_hi",   64'(hi),   64'h55);
        check("cancel_done_lo",   64'(lo),   64'hFFFFFFFF);
        check("cancel_done_dbz",  64'(div_by_zero), 64'd1);

        // Asynchronous reset mid-RUN, then a fresh multiply.
        issue(OP_MULTU, 32'd6, 32'd7);
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
        end
        #2 reset = 1'b1;
        #1;
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_done", 64'(done), 64'd0);
        check("arst_hi",   64'(hi),   64'd0);
        check("arst_lo",   64'(lo),   64'd0);
        check("arst_dbz",  64'(div_by_zero), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        issue(OP_MULTU, 32'd6, 32'd7);
        wait_done(lat);
        check("post_rst_lat", 64'(lat), 64'd34);
        check("post_rst_hi",  64'(hi),  64'd0);
        check("post_rst_lo",  64'(lo),  64'd42);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
